// File: rtl/sonic_block_sync_66.sv
// 10GBASE-R block synchronizer: bit-slip alignment of raw 66-bit gearbox words
// plus sync-header lock tracking; emits aligned blocks and a lock-gated write request.
module sonic_block_sync_66 #(
  parameter int unsigned GOOD_LIMIT    = 64,
  parameter int unsigned WINDOW        = 1024,
  parameter int unsigned INVALID_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [65:0] data_in,
  input  logic        data_valid,
  output logic [65:0] data_out,
  output logic        wrreq,
  output logic        block_lock,
  output logic [6:0]  slip_offset,
  output logic [15:0] err_count
);

  localparam int unsigned W     = 66;
  localparam int unsigned WIN_W = 2 * W;
  localparam int unsigned OFF_W = 7;
  localparam int unsigned SH_W  = 11;
  localparam int unsigned INV_W = 5;
  localparam int unsigned ERR_W = 16;

  logic [W-1:0]     r_prev;
  logic [SH_W-1:0]  r_sh_cnt;
  logic [INV_W-1:0] r_inv_cnt;

  logic [WIN_W-1:0] w_window;
  logic [OFF_W-1:0] w_base;
  logic [W-1:0]     w_cand;
  logic             w_hdr_ok;
  logic [SH_W-1:0]  w_sh_inc;
  logic [INV_W-1:0] w_inv_inc;
  logic [OFF_W-1:0] w_slip_off;
  logic [ERR_W-1:0] w_err_inc;

  // Offset 0 selects the current word; each slip reaches one bit further back
  // into the previous word, so the first word after a clear is usable directly.
  always_comb begin
    w_window   = {data_in, r_prev};
    w_base     = OFF_W'(W) - slip_offset;
    w_cand     = W'(w_window >> w_base);
    w_hdr_ok   = w_cand[0] ^ w_cand[1];
    w_sh_inc   = r_sh_cnt + SH_W'(1);
    w_inv_inc  = r_inv_cnt + {{(INV_W-1){1'b0}}, ~w_hdr_ok};
    w_slip_off = (slip_offset == OFF_W'(W - 1)) ? '0 : slip_offset + OFF_W'(1);
    w_err_inc  = (err_count == '1) ? err_count : err_count + ERR_W'(1);
  end

  // Lock state machine; wrreq uses the lock held before this header's update.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev      <= '0;
      r_sh_cnt    <= '0;
      r_inv_cnt   <= '0;
      data_out    <= '0;
      wrreq       <= 1'b0;
      block_lock  <= 1'b0;
      slip_offset <= '0;
      err_count   <= '0;
    end else if (!enable) begin
      r_prev      <= '0;
      r_sh_cnt    <= '0;
      r_inv_cnt   <= '0;
      data_out    <= '0;
      wrreq       <= 1'b0;
      block_lock  <= 1'b0;
      slip_offset <= '0;
    end else if (data_valid) begin
      r_prev   <= data_in;
      data_out <= w_cand;
      wrreq    <= block_lock;
      if (!block_lock) begin
        if (!w_hdr_ok) begin
          slip_offset <= w_slip_off;
          r_sh_cnt    <= '0;
          r_inv_cnt   <= '0;
        end else if (w_sh_inc == SH_W'(GOOD_LIMIT)) begin
          block_lock <= 1'b1;
          r_sh_cnt   <= '0;
          r_inv_cnt  <= '0;
        end else begin
          r_sh_cnt <= w_sh_inc;
        end
      end else begin
        if (!w_hdr_ok) begin
          err_count <= w_err_inc;
        end
        if (!w_hdr_ok && (w_inv_inc == INV_W'(INVALID_LIMIT))) begin
          slip_offset <= w_slip_off;
          block_lock  <= 1'b0;
          r_sh_cnt    <= '0;
          r_inv_cnt   <= '0;
        end else if (w_sh_inc == SH_W'(WINDOW)) begin
          r_sh_cnt  <= '0;
          r_inv_cnt <= '0;
        end else begin
          r_sh_cnt  <= w_sh_inc;
          r_inv_cnt <= w_inv_inc;
        end
      end
    end else begin
      wrreq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sonic_block_sync_66.sv
// Scoreboard bench for sonic_block_sync_66: a behavioural model queues the
// expected registered outputs per cycle; scenario checks cover lock, slip and clear cases.
module tb_sonic_block_sync_66;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [65:0] data_in;
  logic        data_valid;
  logic [65:0] data_out;
  logic        wrreq;
  logic        block_lock;
  logic [6:0]  slip_offset;
  logic [15:0] err_count;

  sonic_block_sync_66 dut (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .data_out(data_out), .wrreq(wrreq),
    .block_lock(block_lock), .slip_offset(slip_offset), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [65:0] dout;
    logic        wr;
    logic        lock;
    logic [6:0]  off;
    logic [15:0] err;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_bad   = 0;
  int n_wr    = 0;

  logic [65:0] m_prev, m_dout;
  logic        m_wr, m_lock;
  int          m_off, m_sh, m_inv;
  logic [15:0] m_err;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_slip();
    m_off  = (m_off == 65) ? 0 : m_off + 1;
    m_sh   = 0;
    m_inv  = 0;
    m_lock = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic dv, input logic [65:0] din);
    logic [65:0] cand;
    logic        ok;
    int          idx;
    if (rst) begin
      m_prev = '0; m_dout = '0; m_wr = 1'b0; m_lock = 1'b0;
      m_off = 0; m_sh = 0; m_inv = 0; m_err = '0;
    end else if (!en) begin
      m_prev = '0; m_dout = '0; m_wr = 1'b0; m_lock = 1'b0;
      m_off = 0; m_sh = 0; m_inv = 0;
    end else if (!dv) begin
      m_wr = 1'b0;
    end else begin
      for (int j = 0; j < 66; j++) begin
        idx = 66 - m_off + j;
        if (idx >= 66) cand[j] = din[idx-66];
        else           cand[j] = m_prev[idx];
      end
      ok     = (cand[1:0] == 2'b01) || (cand[1:0] == 2'b10);
      m_dout = cand;
      m_wr   = m_lock;
      m_prev = din;
      if (!m_lock) begin
        if (!ok) m_slip();
        else begin
          m_sh++;
          if (m_sh == 64) begin
            m_lock = 1'b1; m_sh = 0; m_inv = 0;
          end
        end
      end else begin
        m_sh++;
        if (!ok) begin
          m_inv++;
          if (m_err != 16'hFFFF) m_err++;
        end
        if (m_inv == 16) m_slip();
        else if (m_sh == 1024) begin
          m_sh = 0; m_inv = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic en, input logic dv, input logic [65:0] din);
    exp_t e;
    reset = rst; enable = en; data_valid = dv; data_in = din;
    model_step(rst, en, dv, din);
    q.push_back('{dout: m_dout, wr: m_wr, lock: m_lock, off: 7'(m_off), err: m_err});
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("data_out", data_out, e.dout);
    chk("wrreq", 66'(wrreq), 66'(e.wr));
    chk("block_lock", 66'(block_lock), 66'(e.lock));
    chk("slip_offset", 66'(slip_offset), 66'(e.off));
    chk("err_count", 66'(err_count), 66'(e.err));
    if (wrreq) n_wr++;
  endtask

  function automatic logic [65:0] mk_word(input logic [1:0] hdr);
    return {$urandom, $urandom, hdr};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [65:0] w17;
    int lock_word;
    int ninv;
    int p;
    logic dropped;
    w17 = 66'd1 << 49;
    clock = 1'b0; reset = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = '0;

    // reset state
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, mk_word(2'b01));
    chk("rst_lock", 66'(block_lock), 66'd0);
    chk("rst_wrreq", 66'(wrreq), 66'd0);
    chk("rst_dout", data_out, 66'd0);
    chk("rst_err", 66'(err_count), 66'd0);

    // aligned clean stream
    n_wr = 0; lock_word = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b0, 1'b1, 1'b1, mk_word(2'b01));
      if (block_lock && lock_word == 0) lock_word = i;
    end
    chk("aligned_lock_word", 66'(lock_word), 66'd64);
    chk("aligned_wr_count", 66'(n_wr), 66'd36);
    chk("aligned_offset", 66'(slip_offset), 66'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("idle_wrreq", 66'(wrreq), 66'd0);

    // stream misaligned by 17 bits
    cyc(1'b1, 1'b1, 1'b0, '0);
    n_wr = 0; lock_word = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b0, 1'b1, 1'b1, w17);
      if (i == 17) chk("mis_offset17", 66'(slip_offset), 66'd17);
      if (block_lock && lock_word == 0) lock_word = i;
      if (wrreq) chk("mis_hdr_ok", 66'(data_out[0] ^ data_out[1]), 66'd1);
    end
    chk("mis_lock_word", 66'(lock_word), 66'd81);
    chk("mis_offset_final", 66'(slip_offset), 66'd17);
    chk("mis_wr_count", 66'(n_wr), 66'd19);

    // slip wrap 65 -> 0
    cyc(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 65; i++) cyc(1'b0, 1'b1, 1'b1, '0);
    chk("wrap_at65", 66'(slip_offset), 66'd65);
    cyc(1'b0, 1'b1, 1'b1, '0);
    chk("wrap_to0", 66'(slip_offset), 66'd0);

    // loss of lock after 16 invalid headers in one window
    cyc(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b1, mk_word(2'b01));
    ninv = 0;
    for (int i = 1; i <= 200; i++) begin
      if (i % 10 == 5 && ninv < 15) begin
        cyc(1'b0, 1'b1, 1'b1, mk_word(2'b11));
        ninv++;
      end else begin
        cyc(1'b0, 1'b1, 1'b1, mk_word(2'b01));
      end
    end
    chk("loss15_lock", 66'(block_lock), 66'd1);
    chk("loss15_err", 66'(err_count), 66'd15);
    cyc(1'b0, 1'b1, 1'b1, mk_word(2'b00));
    chk("loss16_lock", 66'(block_lock), 66'd0);
    chk("loss16_offset", 66'(slip_offset), 66'd1);
    chk("loss16_err", 66'(err_count), 66'd16);
    chk("loss16_wrreq", 66'(wrreq), 66'd1);

    // window reset: 15 invalid per window across two windows
    cyc(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b1, mk_word(2'b01));
    dropped = 1'b0;
    for (int i = 1; i <= 2048; i++) begin
      p = (i - 1) % 1024;
      if (p % 64 == 10 && p / 64 < 15) cyc(1'b0, 1'b1, 1'b1, mk_word(2'b11));
      else                             cyc(1'b0, 1'b1, 1'b1, mk_word(2'b01));
      if (!block_lock) dropped = 1'b1;
    end
    chk("window_no_drop", 66'(dropped), 66'd0);
    chk("window_err30", 66'(err_count), 66'd30);

    // enable low and reset mid-lock
    cyc(1'b0, 1'b0, 1'b1, w17);
    for (int i = 0; i < 90; i++) cyc(1'b0, 1'b1, 1'b1, w17);
    chk("relock_lock", 66'(block_lock), 66'd1);
    chk("relock_offset", 66'(slip_offset), 66'd17);
    cyc(1'b0, 1'b0, 1'b1, w17);
    chk("en_lock", 66'(block_lock), 66'd0);
    chk("en_offset", 66'(slip_offset), 66'd0);
    chk("en_err_kept", 66'(err_count), 66'd30);
    chk("en_dout", data_out, 66'd0);
    for (int i = 0; i < 70; i++) cyc(1'b0, 1'b1, 1'b1, mk_word(2'b01));
    cyc(1'b1, 1'b1, 1'b1, mk_word(2'b01));
    chk("rst2_err", 66'(err_count), 66'd0);
    chk("rst2_lock", 66'(block_lock), 66'd0);
    chk("rst2_wrreq", 66'(wrreq), 66'd0);
    chk("rst2_dout", data_out, 66'd0);
    chk("rst2_offset", 66'(slip_offset), 66'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
